// File: rtl/cal_ctrl_pkg.sv
// Shared types and helpers for the alarm-clock mode/enable sequencer.
// Holds the mode encoding, month index constants and the month-length lookup.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TSET = 2'd1,
        ASET = 2'd2
    } mode_t;

    // 0-based month indices of the short months
    localparam logic [3:0] FEB = 4'd1;
    localparam logic [3:0] APR = 4'd3;
    localparam logic [3:0] JUN = 4'd5;
    localparam logic [3:0] SEP = 4'd8;
    localparam logic [3:0] NOV = 4'd10;

    // Last valid 0-based date of a month; leap only matters for February.
    function automatic logic [4:0] month_last(input logic [3:0] month, input logic leap);
        logic [4:0] last;
        if (month == FEB) begin
            last = leap ? 5'd28 : 5'd27;
        end else if ((month == APR) || (month == JUN) || (month == SEP) || (month == NOV)) begin
            last = 5'd29;
        end else begin
            last = 5'd30;
        end
        return last;
    endfunction

endpackage

// File: rtl/cal_ctrl_adv_rpt.sv
// Advance-button conditioner: rising-edge advance plus tick-based auto-repeat.
// The button must be pressed while 'active' to arm; a button already held when
// it becomes active stays disarmed until released and pressed again.
module adv_rpt #(
    parameter int HOLD_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    input  logic active,
    output logic adv
);

    localparam int CW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

    logic          prev_q, prev_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;

    // Edge detect against the registered level, arm on press, count held ticks
    always_comb begin
        rise    = btn & ~prev_q;
        prev_d  = btn;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        if (!btn || !active) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (rise) begin
            armed_d = 1'b1;
            adv     = 1'b1;
        end else if (armed_q && tick) begin
            if (cnt_q == HOLD_MAX) begin
                adv = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Button history and repeat state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cal_ctrl.sv
// Mode/enable sequencer for the alarm-clock datapath.
// Owns the RUN/TSET/ASET mode machine and issues one-cycle registered enables
// for the time counters and alarm registers, the date early reset and the
// seconds clear. Optional macro LEAP_YEAR_EN adds a 2-bit year counter that
// lengthens February to 29 days when the year count is 0.
module cal_ctrl
    import clock_pkg::*;
#(
    parameter int NS         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int NM         = 12,
    parameter int HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       timeset,
    input  logic       alarmset,
    input  logic       minadv,
    input  logic       hrsadv,
    input  logic       dayadv,
    input  logic       dateadv,
    input  logic       monthadv,
    input  logic [6:0] t_sec,
    input  logic [6:0] t_min,
    input  logic [6:0] t_hrs,
    input  logic [2:0] t_day,
    input  logic [4:0] t_date,
    input  logic [3:0] t_month,
    output logic       sec_en,
    output logic       min_en,
    output logic       hrs_en,
    output logic       day_en,
    output logic       date_en,
    output logic       month_en,
    output logic       date_erst,
    output logic       sec_clr,
    output logic       amin_en,
    output logic       ahrs_en,
    output logic       disp_alarm,
    output logic [1:0] mode
);

    mode_t mode_q, mode_d;
    logic  stay_tset, stay_aset;
    logic  min_adv, hrs_adv, day_adv, date_adv, month_adv;
    logic  leap;
    logic  [4:0] date_last;
    logic  date_wrap;
    logic  c_sec, c_min, c_hrs, c_day, c_mon;

    logic sec_en_q, sec_en_d, min_en_q, min_en_d, hrs_en_q, hrs_en_d;
    logic day_en_q, day_en_d, date_en_q, date_en_d, month_en_q, month_en_d;
    logic date_erst_q, date_erst_d, sec_clr_q, sec_clr_d;
    logic amin_en_q, amin_en_d, ahrs_en_q, ahrs_en_d;
    logic disp_alarm_q, disp_alarm_d;

`ifdef LEAP_YEAR_EN
    logic [1:0] year_q, year_d;
`endif

    // Day-of-week steps as a plain counter, so its value and modulus are not
    // needed here; NM is only consulted when the year counter is built in.
    logic unused_inputs;
    assign unused_inputs = ^{t_day, 3'(ND), 4'(NM)};

    // Mode next-state: both mode buttons together force RUN; TSET/ASET only via RUN
    always_comb begin
        mode_d = mode_q;
        if (timeset && alarmset) begin
            mode_d = RUN;
        end else begin
            case (mode_q)
                RUN:     if (timeset) mode_d = TSET;
                         else if (alarmset) mode_d = ASET;
                TSET:    if (!timeset) mode_d = RUN;
                ASET:    if (!alarmset) mode_d = RUN;
                default: mode_d = RUN;
            endcase
        end
    end

    // A button edge is honoured only if the mode is not being left this cycle
    assign stay_tset = (mode_q == TSET) && (mode_d == TSET);
    assign stay_aset = (mode_q == ASET) && (mode_d == ASET);

    adv_rpt #(.HOLD_TICKS(HOLD_TICKS)) u_min_rpt (
        .clk(clk), .rst(rst), .tick(tick), .btn(minadv),
        .active(stay_tset | stay_aset), .adv(min_adv)
    );
    adv_rpt #(.HOLD_TICKS(HOLD_TICKS)) u_hrs_rpt (
        .clk(clk), .rst(rst), .tick(tick), .btn(hrsadv),
        .active(stay_tset | stay_aset), .adv(hrs_adv)
    );
    adv_rpt #(.HOLD_TICKS(HOLD_TICKS)) u_day_rpt (
        .clk(clk), .rst(rst), .tick(tick), .btn(dayadv),
        .active(stay_tset), .adv(day_adv)
    );
    adv_rpt #(.HOLD_TICKS(HOLD_TICKS)) u_date_rpt (
        .clk(clk), .rst(rst), .tick(tick), .btn(dateadv),
        .active(stay_tset), .adv(date_adv)
    );
    adv_rpt #(.HOLD_TICKS(HOLD_TICKS)) u_month_rpt (
        .clk(clk), .rst(rst), .tick(tick), .btn(monthadv),
        .active(stay_tset), .adv(month_adv)
    );

    // Tick carry chain (RUN/ASET) and month-end detection from sampled counters
    always_comb begin
`ifdef LEAP_YEAR_EN
        leap = (year_q == 2'd0);
`else
        leap = 1'b0;
`endif
        date_last = month_last(t_month, leap);
        // Out-of-range dates are treated as the last date so they recover
        date_wrap = (t_date >= date_last);
        c_sec     = (mode_q != TSET) && tick;
        c_min     = c_sec && (t_sec == 7'(NS - 1));
        c_hrs     = c_min && (t_min == 7'(NS - 1));
        c_day     = c_hrs && (t_hrs == 7'(NH - 1));
        c_mon     = c_day && date_wrap;
    end

    // Enable merge: advance buttons step only their own field, never carry
    always_comb begin
        sec_en_d     = c_sec;
        min_en_d     = c_min | ((mode_q == TSET) & min_adv);
        hrs_en_d     = c_hrs | ((mode_q == TSET) & hrs_adv);
        day_en_d     = c_day | day_adv;
        date_en_d    = c_day | date_adv;
        date_erst_d  = (c_day | date_adv) & date_wrap;
        month_en_d   = c_mon | month_adv;
        amin_en_d    = (mode_q == ASET) & min_adv;
        ahrs_en_d    = (mode_q == ASET) & hrs_adv;
        sec_clr_d    = (mode_q == TSET) && (mode_d != TSET);
        disp_alarm_d = (mode_d == ASET);
`ifdef LEAP_YEAR_EN
        year_d = year_q;
        if (c_mon && (t_month == 4'(NM - 1))) begin
            year_d = year_q + 2'd1;
        end
`endif
    end

    // Mode state and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q       <= RUN;
            sec_en_q     <= 1'b0;
            min_en_q     <= 1'b0;
            hrs_en_q     <= 1'b0;
            day_en_q     <= 1'b0;
            date_en_q    <= 1'b0;
            month_en_q   <= 1'b0;
            date_erst_q  <= 1'b0;
            sec_clr_q    <= 1'b0;
            amin_en_q    <= 1'b0;
            ahrs_en_q    <= 1'b0;
            disp_alarm_q <= 1'b0;
`ifdef LEAP_YEAR_EN
            year_q       <= 2'd0;
`endif
        end else begin
            mode_q       <= mode_d;
            sec_en_q     <= sec_en_d;
            min_en_q     <= min_en_d;
            hrs_en_q     <= hrs_en_d;
            day_en_q     <= day_en_d;
            date_en_q    <= date_en_d;
            month_en_q   <= month_en_d;
            date_erst_q  <= date_erst_d;
            sec_clr_q    <= sec_clr_d;
            amin_en_q    <= amin_en_d;
            ahrs_en_q    <= ahrs_en_d;
            disp_alarm_q <= disp_alarm_d;
`ifdef LEAP_YEAR_EN
            year_q       <= year_d;
`endif
        end
    end

    assign mode       = mode_q;
    assign sec_en     = sec_en_q;
    assign min_en     = min_en_q;
    assign hrs_en     = hrs_en_q;
    assign day_en     = day_en_q;
    assign date_en    = date_en_q;
    assign month_en   = month_en_q;
    assign date_erst  = date_erst_q;
    assign sec_clr    = sec_clr_q;
    assign amin_en    = amin_en_q;
    assign ahrs_en    = ahrs_en_q;
    assign disp_alarm = disp_alarm_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// Scoreboard bench for cal_ctrl: stimulus pushes hand-computed output vectors
// tagged with the cycle they must appear in; a monitor pops and compares.
// Output vector bit order:
// {sec,min,hrs,day,date,month,erst,clr,amin,ahrs,disp,mode[1:0]}
module tb_cal_ctrl;

    localparam logic [12:0] SEC  = 13'h1000;
    localparam logic [12:0] MIN  = 13'h0800;
    localparam logic [12:0] HRS  = 13'h0400;
    localparam logic [12:0] DAY  = 13'h0200;
    localparam logic [12:0] DATE = 13'h0100;
    localparam logic [12:0] MON  = 13'h0080;
    localparam logic [12:0] ERST = 13'h0040;
    localparam logic [12:0] CLR  = 13'h0020;
    localparam logic [12:0] AMIN = 13'h0010;
    localparam logic [12:0] AHRS = 13'h0008;
    localparam logic [12:0] DISP = 13'h0004;
    localparam logic [12:0] MT   = 13'h0001;
    localparam logic [12:0] MA   = 13'h0002;
    localparam logic [12:0] CHAIN = SEC | MIN | HRS | DAY | DATE;
    localparam logic [12:0] ASD   = MA | DISP;

    logic clk = 1'b0;
    logic rst, tick, timeset, alarmset;
    logic minadv, hrsadv, dayadv, dateadv, monthadv;
    logic [6:0] t_sec, t_min, t_hrs;
    logic [2:0] t_day;
    logic [4:0] t_date;
    logic [3:0] t_month;
    logic sec_en, min_en, hrs_en, day_en, date_en, month_en;
    logic date_erst, sec_clr, amin_en, ahrs_en, disp_alarm;
    logic [1:0] mode;

    always #5 clk = ~clk;

    cal_ctrl #(.NS(60), .NH(24), .ND(7), .NM(12), .HOLD_TICKS(2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
        .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv), .dateadv(dateadv),
        .monthadv(monthadv), .t_sec(t_sec), .t_min(t_min), .t_hrs(t_hrs),
        .t_day(t_day), .t_date(t_date), .t_month(t_month),
        .sec_en(sec_en), .min_en(min_en), .hrs_en(hrs_en), .day_en(day_en),
        .date_en(date_en), .month_en(month_en), .date_erst(date_erst),
        .sec_clr(sec_clr), .amin_en(amin_en), .ahrs_en(ahrs_en),
        .disp_alarm(disp_alarm), .mode(mode)
    );

    typedef struct {
        int          tgt;
        string       name;
        logic [12:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    logic [12:0] act;

    assign act = {sec_en, min_en, hrs_en, day_en, date_en, month_en, date_erst,
                  sec_clr, amin_en, ahrs_en, disp_alarm, mode};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].tgt <= cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                if (e.tgt < cyc)
                    $display("FAIL %s: sample slot %0d missed (now %0d)", e.name, e.tgt, cyc);
                else if (act !== e.exp)
                    $display("FAIL %s: got %013b expected %013b", e.name, act, e.exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic set_t(input int s, input int m, input int h, input int d, input int mo);
        t_sec = 7'(s); t_min = 7'(m); t_hrs = 7'(h); t_date = 5'(d); t_month = 4'(mo);
    endtask

    // Hold current inputs for one cycle; expect e on the registered outputs
    task automatic step(input string n, input logic [12:0] e);
        sb_q.push_back('{tgt: cyc + 1, name: n, exp: e});
        @(posedge clk);
        #1;
    endtask

    // One tick cycle followed by two idle cycles (ticks stay >= 3 clocks apart)
    task automatic tick_step(input string n, input logic [12:0] e_tick, input logic [12:0] e_idle);
        tick = 1'b1;
        step(n, e_tick);
        tick = 1'b0;
        step({n, "_gap"}, e_idle);
        step({n, "_gap"}, e_idle);
    endtask

    initial begin
        int waited;
        rst = 1'b0; tick = 1'b0; timeset = 1'b0; alarmset = 1'b0;
        minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0; dateadv = 1'b0; monthadv = 1'b0;
        t_day = 3'd0;
        set_t(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{tgt: cyc, name: "reset_state", exp: 13'h0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("idle_run", 13'h0);

        // RUN carry chain
        set_t(59, 59, 23, 30, 0);
        tick_step("run_full_wrap", CHAIN | MON | ERST, 13'h0);
        set_t(10, 0, 0, 0, 0);
        tick_step("run_sec", SEC, 13'h0);
        set_t(59, 3, 0, 0, 0);
        tick_step("run_min", SEC | MIN, 13'h0);
        set_t(59, 59, 5, 0, 0);
        tick_step("run_hrs", SEC | MIN | HRS, 13'h0);
        set_t(59, 59, 23, 27, 1);
`ifdef LEAP_YEAR_EN
        tick_step("feb_27_leap", CHAIN, 13'h0);
`else
        tick_step("feb_27", CHAIN | MON | ERST, 13'h0);
`endif
        set_t(59, 59, 23, 29, 1);
        tick_step("feb_corrupt", CHAIN | MON | ERST, 13'h0);
        set_t(59, 59, 23, 28, 3);
        tick_step("apr_28", CHAIN, 13'h0);
        set_t(59, 59, 23, 29, 3);
        tick_step("apr_29", CHAIN | MON | ERST, 13'h0);
`ifdef LEAP_YEAR_EN
        set_t(59, 59, 23, 30, 11);
        tick_step("dec_wrap_year", CHAIN | MON | ERST, 13'h0);
        set_t(59, 59, 23, 27, 1);
        tick_step("feb_27_nonleap", CHAIN | MON | ERST, 13'h0);
`endif

        // TSET: own-field steps, no tick carry, repeat after two held ticks
        set_t(0, 0, 0, 0, 0);
        timeset = 1'b1;
        step("tset_enter", MT);
        step("tset_hold", MT);
        set_t(0, 0, 0, 29, 3);
        dateadv = 1'b1;
        step("tset_date_wrap", MT | DATE | ERST);
        tick_step("tset_tick1", MT, MT);
        tick_step("tset_tick2", MT, MT);
        tick_step("tset_repeat", MT | DATE | ERST, MT);
        dateadv = 1'b0;
        step("tset_date_rel", MT);
        set_t(0, 59, 23, 10, 3);
        dateadv = 1'b1;
        step("tset_date_mid", MT | DATE);
        dateadv = 1'b0;
        minadv = 1'b1; hrsadv = 1'b1;
        step("tset_min_hrs", MT | MIN | HRS);
        minadv = 1'b0; hrsadv = 1'b0;
        step("tset_rel", MT);
        set_t(0, 0, 0, 30, 0);
        monthadv = 1'b1;
        step("tset_month", MT | MON);
        monthadv = 1'b0;
        dayadv = 1'b1;
        step("tset_day", MT | DAY);
        dayadv = 1'b0;
        step("tset_rel2", MT);
        timeset = 1'b0; minadv = 1'b1;
        step("tset_exit_drop", CLR);
        step("run_held_min", 13'h0);
        minadv = 1'b0;
        step("run_idle", 13'h0);

        // ASET: alarm enables, time keeps running, date/day/month ignored
        set_t(0, 0, 0, 0, 0);
        alarmset = 1'b1;
        step("aset_enter", ASD);
        minadv = 1'b1;
        step("aset_amin_edge", ASD | AMIN);
        tick_step("aset_tick1", SEC | ASD, ASD);
        tick_step("aset_tick2", SEC | ASD, ASD);
        tick_step("aset_tick3", SEC | ASD | AMIN, ASD);
        tick_step("aset_tick4", SEC | ASD | AMIN, ASD);
        tick_step("aset_tick5", SEC | ASD | AMIN, ASD);
        minadv = 1'b0;
        step("aset_rel", ASD);
        hrsadv = 1'b1; dayadv = 1'b1; dateadv = 1'b1; monthadv = 1'b1;
        step("aset_ahrs_only", ASD | AHRS);
        hrsadv = 1'b0; dayadv = 1'b0; dateadv = 1'b0; monthadv = 1'b0;
        step("aset_rel2", ASD);
        alarmset = 1'b0;
        step("aset_exit", 13'h0);

        // Both mode buttons: stay in RUN, advances ignored
        timeset = 1'b1; alarmset = 1'b1; minadv = 1'b1; dayadv = 1'b1;
        step("both_btn", 13'h0);
        tick_step("both_tick", SEC, 13'h0);
        timeset = 1'b0; alarmset = 1'b0; minadv = 1'b0; dayadv = 1'b0;
        step("both_rel", 13'h0);

        // Button held on mode entry: no advance or repeat until re-pressed
        minadv = 1'b1;
        step("pre_held", 13'h0);
        timeset = 1'b1;
        step("held_enter", MT);
        step("held_stay", MT);
        tick_step("held_tick1", MT, MT);
        tick_step("held_tick2", MT, MT);
        tick_step("held_tick3", MT, MT);
        minadv = 1'b0;
        step("held_rel", MT);
        minadv = 1'b1;
        step("held_repress", MT | MIN);
        step("held_armed", MT);

        // Asynchronous reset mid-TSET with minadv held
        sb_q.push_back('{tgt: cyc + 1, name: "rst_async", exp: 13'h0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("in_reset", 13'h0);
        rst = 1'b1;
        step("rst_release", MT);
        step("post_rst", MT);
        tick_step("post_rst_tick1", MT, MT);
        tick_step("post_rst_tick2", MT, MT);
        tick_step("post_rst_tick3", MT, MT);
        minadv = 1'b0;
        step("post_rst_rel", MT);
        minadv = 1'b1;
        step("post_rst_repress", MT | MIN);
        minadv = 1'b0; timeset = 1'b0;
        step("final_exit", CLR);
        step("final_idle", 13'h0);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cal_ctrl.md
Name: cal_ctrl

Overview:
Mode/enable sequencer for the alarm-clock datapath. It owns the RUN / TIME-SET / ALARM-SET mode state machine and generates every count-enable for the time counters (sec, min, hrs, day, date, month) and the alarm registers (amin, ahrs). It also generates the date early-reset from a month-length table and auto-repeats held advance buttons. The counters stay plain mod-N counters; this block decides when each one steps.

Parameters:
NS, 60, modulus of seconds/minutes counters
NH, 24, modulus of hours counter
ND, 7, modulus of day-of-week counter
NM, 12, modulus of month counter (month 0-based, 0=Jan)
HOLD_TICKS, 2, ticks a button must stay held before auto-repeat starts

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-cycle strobe, 1/sec; ≥3 clk cycles apart
timeset  in  1  time-set mode button
alarmset  in  1  alarm-set mode button
minadv, hrsadv, dayadv, dateadv, monthadv  in  1 each  advance buttons (level)
t_sec, t_min, t_hrs  in  7 each  current counter values
t_day  in  3  current day-of-week
t_date  in  5  current date, 0-based
t_month  in  4  current month, 0-based
sec_en, min_en, hrs_en, day_en, date_en, month_en  out  1 each  counter enables
date_erst  out  1  date early reset (to 0), qualified with date_en
sec_clr  out  1  synchronous clear of seconds counter
amin_en, ahrs_en  out  1 each  alarm register enables
disp_alarm  out  1  display mux select, 1 = show alarm min/hrs
mode  out  2  current mode (RUN=0, TSET=1, ASET=2)

Behaviour:
- Reset (rst=0, async): mode=RUN; all enables, date_erst, sec_clr and disp_alarm = 0; repeat counters and button history = 0.
- All outputs registered. Enables are 1-clk pulses, asserted the cycle after the qualifying event and computed from the t_* values sampled in the event cycle.
- Mode FSM, evaluated every clk:
  - RUN→TSET when timeset & !alarmset.
  - RUN→ASET when alarmset & !timeset.
  - TSET→RUN when !timeset. ASET→RUN when !alarmset.
  - timeset & alarmset together: forced to RUN.
  - TSET↔ASET only via RUN.
- Leaving TSET: sec_clr pulses for 1 cycle.
- disp_alarm = 1 exactly while mode==ASET.
- RUN and ASET mode, on tick (carry chain):
  - sec_en=1.
  - min_en when t_sec==NS-1.
  - hrs_en when additionally t_min==NS-1.
  - day_en and date_en when additionally t_hrs==NH-1.
  - Month length: 28 for month 1; 30 for months 3, 5, 8, 10; 31 otherwise.
  - At the hour-wrap tick with t_date==len-1: date_erst=1 and month_en=1 in the same cycle.
  - If t_date > len-1 (corrupt value, e.g. date 30 in Feb), treat as last date: erst + month_en.
- TSET mode:
  - sec_en=0; time never carries.
  - Each advance button steps only its own counter; no carry into the next field.
  - dateadv at t_date==len-1 asserts date_en+date_erst and leaves month_en at 0.
  - monthadv does not alter date.
- ASET mode:
  - minadv→amin_en and hrsadv→ahrs_en, no carry.
  - dayadv, dateadv, monthadv are ignored.
  - The time counters keep running.
- Advance buttons (per button):
  - Rising edge (vs registered previous level) → one advance pulse next cycle, independent of tick.
  - While the button stays high, count ticks. Once HOLD_TICKS ticks have elapsed, issue one advance on every subsequent tick.
  - Release clears the count.
  - A button already held when its mode is entered does not advance until released and re-pressed.
- Simultaneous events:
  - Multiple advance buttons at once: each enable asserts independently.
  - A mode exit on the same cycle as an edge: the edge is dropped.

Optional Feature:
LEAP_YEAR_EN:
- Defined: internal 2-bit year counter. It resets to 0 and increments on the month_en pulse issued in the RUN/ASET carry chain when t_month==NM-1.
- With the year counter ==0, February length is 29.
- monthadv in TSET never changes the year counter.
- Not defined: February is always 28; no year state.

Decomposition:
- Package clock_pkg holds:
  - mode_t enum (RUN, TSET, ASET);
  - month index constants (FEB=1, APR=3, JUN=5, SEP=8, NOV=10);
  - function month_last(month, leap) returning the last 0-based date.
- Sub-module adv_rpt (edge detect + hold-tick repeat counter, parameter HOLD_TICKS) is instantiated once per advance button.

Test Plan:
- RUN, t_sec=59, t_min=59, t_hrs=23, t_date=30, t_month=0, tick → sec/min/hrs/day/date_en, date_erst and month_en all 1 in the same cycle.
- RUN, t_month=1, t_date=27, at hour wrap → date_erst=1, month_en=1. With LEAP_YEAR_EN and year=0: same stimulus gives date_en only, no erst/month_en.
- TSET, t_date=29, t_month=3, dateadv edge → date_en=1, date_erst=1, month_en=0, sec_en stays 0 across ticks. Releasing timeset → sec_clr one cycle, mode=RUN.
- ASET, minadv held 5 ticks, HOLD_TICKS=2 → amin_en at the edge and at ticks 3, 4, 5 (4 pulses total). disp_alarm=1; sec_en continues each tick.
- timeset and alarmset both high from RUN → mode stays RUN, no advances honoured.
- Drop rst mid-TSET with minadv held → all outputs 0 immediately. After release, no min_en until minadv is re-pressed.
